// File: rtl/spi_pkg.sv
// Shared types and default widths for the SPI frame slave.
package spi_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RX = 2'd1, WAIT = 2'd2, TX = 2'd3} spi_state_t;
  localparam int SPI_IN_W_DEF  = 256;
  localparam int SPI_OUT_W_DEF = 128;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with registered rise/fall pulses; an edge pulse
// appears SYNC_STAGES+1 clk cycles after the pin changes.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_q;

  assign w_q = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= w_q;
      r_rise <= w_q & ~r_prev;
      r_fall <= ~w_q & r_prev;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;
endmodule

// File: rtl/spi_frame_slave.sv
// SPI mode-0 frame slave in the clk domain: receive IN_W-bit request, hand off,
// shift out OUT_W-bit result. Define SPI_FRAME_ERR_EN to report short frames.
module spi_frame_slave
  import spi_pkg::*;
#(
  parameter int IN_W        = SPI_IN_W_DEF,
  parameter int OUT_W       = SPI_OUT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sck,
  input  logic             sdi,
  output logic             sdo,
  input  logic             load,
  output logic [IN_W-1:0]  rx_data,
  output logic             rx_valid,
  input  logic [OUT_W-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             done,
  output logic             frame_err
);
  localparam int MAX_W = (IN_W > OUT_W) ? IN_W : OUT_W;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] CNT_IN      = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] CNT_TX_LAST = CNT_W'(OUT_W - 1);

  spi_state_t             r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic [IN_W-1:0]        r_rx_shift;
  logic [IN_W-1:0]        r_rx_data;
  logic                   r_rx_valid;
  logic [OUT_W-1:0]       r_tx_shift;
  logic                   r_done;

  logic w_sdi;
  logic w_sck_rise, w_sck_fall, w_load_rise, w_load_fall;
  logic w_start, w_abort, w_rx_cap, w_hs, w_tx_end, w_tx_ready;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .i_d    (sck),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_load_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .i_d    (load),
    .o_rise (w_load_rise),
    .o_fall (w_load_fall)
  );

  // sdi only needs to be stable at synchronised sck rise, so no edge logic
  always_ff @(posedge clk) begin
    if (!reset_n) r_sdi_sync <= '0;
    else          r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
  end
  assign w_sdi = r_sdi_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    w_rx_cap    = 1'b0;
    w_hs        = 1'b0;
    w_tx_end    = 1'b0;
    w_tx_ready  = 1'b0;
    case (r_state)
      IDLE: if (w_load_rise) begin
        w_start     = 1'b1;
        w_state_nxt = RX;
      end
      RX: if (w_load_fall) begin
        if (r_cnt == CNT_IN) begin
          w_rx_cap    = 1'b1;
          w_state_nxt = WAIT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      // a new load edge pre-empts a same-cycle handshake
      WAIT: if (w_load_rise) begin
        w_abort     = 1'b1;
        w_state_nxt = RX;
      end else begin
        w_tx_ready = 1'b1;
        if (tx_valid) begin
          w_hs        = 1'b1;
          w_state_nxt = TX;
        end
      end
      TX: if (w_load_rise) begin
        w_abort     = 1'b1;
        w_state_nxt = RX;
      end else if (w_sck_rise && r_cnt == CNT_TX_LAST) begin
        w_tx_end    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_shift <= '0;
      r_done     <= 1'b0;
    end else begin
      r_rx_valid <= w_rx_cap;
      if (w_start || w_abort || w_hs)
        r_cnt <= '0;
      else if (w_sck_rise && ((r_state == RX && r_cnt != CNT_IN) || r_state == TX))
        r_cnt <= r_cnt + 1'b1;
      // over-long frames keep shifting so the newest IN_W bits survive
      if (r_state == RX && w_sck_rise && !w_load_fall)
        r_rx_shift <= {r_rx_shift[IN_W-2:0], w_sdi};
      if (w_rx_cap)
        r_rx_data <= r_rx_shift;
      if (w_hs)
        r_tx_shift <= tx_data;
      else if (w_abort)
        r_tx_shift <= '0;
      else if (r_state == TX && w_sck_fall)
        r_tx_shift <= {r_tx_shift[OUT_W-2:0], 1'b0};
      if (w_hs)
        r_done <= 1'b1;
      else if (w_abort || w_tx_end)
        r_done <= 1'b0;
    end
  end

`ifdef SPI_FRAME_ERR_EN
  logic w_rx_short;
  logic r_frame_err;
  assign w_rx_short = (r_state == RX) && w_load_fall && (r_cnt != CNT_IN);
  always_ff @(posedge clk) begin
    if (!reset_n) r_frame_err <= 1'b0;
    else          r_frame_err <= w_rx_short;
  end
  assign frame_err = r_frame_err;
`else
  assign frame_err = 1'b0;
`endif

  assign sdo      = (r_state == TX) ? r_tx_shift[OUT_W-1] : 1'b0;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign tx_ready = w_tx_ready;
  assign done     = r_done;
endmodule
